if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, fetches through a req/ready memory port, and feeds IF_ID.
//  IF_ID presents pc, instruction and prediction to ID.
//  Holds a 2-bit bimodal BHT. Predicts the next PC for B-type and JAL; EX redirects on mispredict.
//  Stalls on the stall bus and flushes in-flight fetches on redirect.
// PARAMETERS
//  RESET_PC   32'h0  PC fetched first after reset
//  BHT_BITS   6      log2 BHT entries; index = pc[BHT_BITS+1:2]
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   reset, synchronous, active-low
//  stall_in        in   1   stall bus: IF_ID will not accept this cycle
//  if_req          out  1   fetch request to memory controller
//  if_addr         out  32  fetch address; stable while if_req=1 and !if_ready
//  if_ready        in   1   one-cycle pulse: if_data valid for current request
//  if_data         in   32  fetched instruction word
//  br_flag         in   1   EX redirect (mispredict); pulse
//  br_target       in   32  correct PC on redirect
//  br_update       in   1   EX resolved a B-type branch; train BHT
//  br_pc           in   32  PC of resolved branch
//  br_taken        in   1   actual outcome of resolved branch
//  out_valid       out  1   out_* hold a real instruction (0 = bubble)
//  out_pc          out  32  PC of offered instruction
//  out_instruction out  32  offered instruction
//  out_prediction  out  1   1 = fetch continued at predicted-taken target
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - pc=RESET_PC; state=FETCH.
//   - if_req=0, if_addr=RESET_PC.
//   - out_valid=0, out_pc=0, out_instruction=0, out_prediction=0.
//   - skid empty; every BHT entry=2'b01 (weak not-taken).
//   - Reset overrides all other inputs, including mid-fetch; a late if_ready is ignored.
//  States: FETCH (request outstanding), HOLD (word in skid, waiting for stall), DISCARD (drop stale response).
//  FETCH:
//   - if_req=1, if_addr=pc. if_req first rises the cycle after reset release.
//   - Next PC from the fetched word:
//     - opcode 1101111 (JAL): pc+J_imm, pred=1.
//     - opcode 1100011 with BHT[idx][1]=1: pc+B_imm, pred=1.
//     - otherwise: pc+4, pred=0. Arithmetic is mod 2^32.
//   - if_ready & !stall_in: out_* <= {1,pc,if_data,pred}; pc<=next; stay FETCH.
//     New if_addr appears on the same edge (back-to-back fetch).
//   - if_ready & stall_in: word+pred go to skid; out_* unchanged; state=HOLD; if_req=0.
//   - !if_ready & !stall_in: out_valid<=0 (bubble); other out_* hold.
//   - stall_in=1 without if_ready: all out_* hold.
//  HOLD:
//   - if_req=0.
//   - On stall_in=0: out_* <= skid; pc<=next; state=FETCH.
//  Redirect br_flag=1 (any state, overrides stall_in):
//   - pc<=br_target, out_valid<=0, skid cleared.
//   - FETCH with if_ready same cycle: word dropped, state=FETCH, if_addr=br_target next cycle.
//   - FETCH without if_ready: state=DISCARD; if_addr keeps old address until if_ready.
//   - HOLD: state=FETCH.
//  DISCARD:
//   - if_req=1 at stale address.
//   - On if_ready: data dropped, state=FETCH.
//   - A further br_flag here only updates pc.
//  BHT training on br_update:
//   - entry at br_pc[BHT_BITS+1:2] saturating +1 if br_taken, else -1; bounds 00..11.
//   - Same-cycle update and lookup of one entry: the lookup sees the pre-update value.
//  Memory latency is unbounded; the block never drops if_req before if_ready.
// TESTING
//  1 Reset, ready every cycle after req, data=32'h00000013 -> out_pc 0,4,8 on consecutive cycles; pred=0.
//  2 Word at pc=8 is JAL imm=+16 -> out_prediction=1; next if_addr=24.
//  3 stall_in=1 for 3 cycles while if_ready pulses -> out_* unchanged; if_req=0 in HOLD;
//    on release out_pc=skid pc, fetch resumes.
//  4 br_flag, target 32'h100, while request at 32'h40 outstanding; if_ready 2 cycles later ->
//    response dropped, out_valid=0, next if_addr=32'h100.
//  5 br_update taken x2 for pc 32'h20 -> counter 01->10->11; then BEQ imm=-8 at 32'h20 ->
//    pred=1, next if_addr=32'h18.
//  6 rst=0 mid-DISCARD with if_ready same edge -> all reset values; first if_addr=RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage
//
// Owns the PC and fetches through a req/ready memory port. Each fetched word
// is offered to ID on the out_* bus together with a branch prediction.
// A 2-bit bimodal BHT predicts B-type branches, and JAL is always taken.
// EX redirects the PC on a mispredict. When ID stalls, the word waits in a
// one-entry skid buffer.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   stall_in              IF_ID cannot accept this cycle
//   if_req / if_addr      fetch request and address (registered)
//   if_ready / if_data    one-cycle response pulse and instruction word
//   br_flag / br_target   redirect from EX (mispredict)
//   br_update / br_pc /
//   br_taken              BHT training from a resolved B-type branch
//   out_valid, out_pc,
//   out_instruction,
//   out_prediction        registered IF_ID payload
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ready,
  input  logic [31:0] if_data,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  input  logic        br_update,
  input  logic [31:0] br_pc,
  input  logic        br_taken,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic        out_prediction
);

  localparam int BHT_N = 1 << BHT_BITS;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t              r_state;
  logic [31:0]         r_pc;
  logic                r_req;
  logic [31:0]         r_addr;
  logic [31:0]         r_skid_instr;
  logic                r_skid_pred;
  logic                r_out_valid;
  logic [31:0]         r_out_pc;
  logic [31:0]         r_out_instr;
  logic                r_out_pred;
  logic [1:0]          r_bht [BHT_N];

  logic [BHT_BITS-1:0] w_idx;
  logic [BHT_BITS-1:0] w_upd_idx;
  logic [32:0]         w_fetch_next;
  logic [32:0]         w_hold_next;
  logic                w_unused;

  // Returns {prediction, next_pc}. For a B-type word the caller supplies the
  // taken bit, so a word in the skid replays the prediction made when it arrived.
  function automatic logic [32:0] f_next(input logic [31:0] pc,
                                         input logic [31:0] instr,
                                         input logic        taken);
    logic [31:0] v_imm;
    logic [32:0] v_res;
    v_imm = 32'h0000_0000;
    if (instr[6:0] == 7'b1101111) begin
      v_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      v_res = {1'b1, pc + v_imm};
    end else if ((instr[6:0] == 7'b1100011) && taken) begin
      v_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      v_res = {1'b1, pc + v_imm};
    end else begin
      v_res = {1'b0, pc + 32'd4};
    end
    return v_res;
  endfunction

  assign w_idx        = r_pc[BHT_BITS+1:2];
  assign w_upd_idx    = br_pc[BHT_BITS+1:2];
  assign w_fetch_next = f_next(r_pc, if_data, r_bht[w_idx][1]);
  assign w_hold_next  = f_next(r_pc, r_skid_instr, r_skid_pred);
  assign w_unused     = ^{br_pc[31:BHT_BITS+2], br_pc[1:0]};

  assign if_req          = r_req;
  assign if_addr         = r_addr;
  assign out_valid       = r_out_valid;
  assign out_pc          = r_out_pc;
  assign out_instruction = r_out_instr;
  assign out_prediction  = r_out_pred;

  // Fetch FSM together with the PC, skid buffer and registered outputs.
  // r_req is low only in HOLD and in the cycle right after reset, so
  // a response arriving while r_req is low is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_skid_instr <= 32'h0000_0000;
      r_skid_pred  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_pc     <= 32'h0000_0000;
      r_out_instr  <= 32'h0000_0000;
      r_out_pred   <= 1'b0;
    end else if (br_flag) begin
      r_pc         <= br_target;
      r_out_valid  <= 1'b0;
      r_skid_instr <= 32'h0000_0000;
      r_skid_pred  <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (r_req && !if_ready) begin
            // The request is still in flight. Keep the address stable and
            // drop the response when it arrives.
            r_state <= S_DISCARD;
          end else begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= br_target;
          end
        end
        S_DISCARD: begin
          if (if_ready) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= br_target;
          end else begin
            r_state <= S_DISCARD;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_addr  <= br_target;
        end
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
            if (!stall_in) begin
              r_out_valid <= 1'b0;
            end
          end else if (if_ready) begin
            if (!stall_in) begin
              r_out_valid <= 1'b1;
              r_out_pc    <= r_pc;
              r_out_instr <= if_data;
              r_out_pred  <= w_fetch_next[32];
              r_pc        <= w_fetch_next[31:0];
              r_addr      <= w_fetch_next[31:0];
            end else begin
              r_skid_instr <= if_data;
              r_skid_pred  <= w_fetch_next[32];
              r_req        <= 1'b0;
              r_state      <= S_HOLD;
            end
          end else if (!stall_in) begin
            r_out_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc;
            r_out_instr <= r_skid_instr;
            r_out_pred  <= r_skid_pred;
            r_pc        <= w_hold_next[31:0];
            r_addr      <= w_hold_next[31:0];
            r_req       <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (if_ready) begin
            r_addr  <= r_pc;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // BHT: a bank of saturating 2-bit counters. The prediction lookup reads the
  // value from before this edge's update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (br_update) begin
      if (br_taken && (r_bht[w_upd_idx] != 2'b11)) begin
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
      end else if (!br_taken && (r_bht[w_upd_idx] != 2'b00)) begin
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
      end
    end
  end

endmodule
